plb_responder: RTL and testbench
================================

PLB_RESPONDER -- requirements
Module: plb_responder

Interface
REQ-001 The block SHALL have parameter DW, default 32: data width of both ports.
REQ-002 The block SHALL have parameter AW, default 10: word-address width; storage is 2^AW words.
REQ-003 The block SHALL have parameter CW, default 16: width of the access counters.
REQ-004 The block SHALL have port clk  input  1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sys_rst  input  1: reset, synchronous and active-high.
REQ-006 The block SHALL have port PLB_en  input  1: PL-side access enable.
REQ-007 The block SHALL have port PLB_we  input  1: PL-side write enable; it is valid only when PLB_en=1.
REQ-008 The block SHALL have port PLB_addr  input  32: PL-side word address.
REQ-009 The block SHALL have port PLB_din  input  signed DW: PL-side write data.
REQ-010 The block SHALL have port PLB_dout  output  signed DW: PL-side read data.
REQ-011 The block SHALL have ports host_en, host_we  input  1 each: host-side enable and write enable.
REQ-012 The block SHALL have port host_addr  input  AW: host-side word address.
REQ-013 The block SHALL have port host_din  input  DW: host-side write data.
REQ-014 The block SHALL have port host_dout  output  DW: host-side read data.
REQ-015 The block SHALL have port plb_wr_cnt  output  CW: count of accepted PL-side writes.
REQ-016 The block SHALL have port plb_rd_cnt  output  CW: count of accepted PL-side reads.
REQ-017 The block SHALL have port err_oor  output  1: sticky flag, PL-side access out of range.
REQ-018 The block SHALL have port err_coll  output  1: sticky flag, same-address write collision.

Function
REQ-019 Storage SHALL be one 2^AW x DW array with two ports; both ports SHALL be usable in the same cycle.
REQ-020 A PL-side access SHALL be in range iff PLB_addr[31:AW]==0, and SHALL then use word index PLB_addr[AW-1:0].
REQ-021 A write (en=1, we=1) on either port SHALL update the array at the clock edge.
REQ-022 A read (en=1, we=0) SHALL present the data on the port's dout exactly 1 cycle after the request.
REQ-023 dout SHALL hold its last value in any cycle with en=0.
REQ-024 A write SHALL leave that port's dout unchanged.
REQ-025 Read-during-write (cross-port, same address, same cycle) SHALL be read-first: the read returns the old word.
REQ-026 If both ports write the same address in the same cycle, the PL-side write SHALL win, the host write SHALL be dropped, and err_coll SHALL be set.
REQ-027 An out-of-range PL-side write SHALL be ignored; err_oor SHALL be set; plb_wr_cnt SHALL be unchanged.
REQ-028 An out-of-range PL-side read SHALL return 0 on PLB_dout after 1 cycle; err_oor SHALL be set; plb_rd_cnt SHALL be unchanged.
REQ-029 plb_wr_cnt SHALL increment on each in-range PL-side write and saturate at 2^CW-1.
REQ-030 plb_rd_cnt SHALL increment on each in-range PL-side read and saturate at 2^CW-1.
REQ-031 err_oor and err_coll SHALL stay set until sys_rst.

Reset
REQ-032 On sys_rst=1 at a clock edge, the following SHALL be 0 from the next cycle: PLB_dout, host_dout, plb_wr_cnt, plb_rd_cnt, err_oor, err_coll.
REQ-033 The array contents SHALL NOT be reset.
REQ-034 Accesses presented in a reset cycle SHALL be discarded: no write, no count, no flag change.
REQ-035 A read issued in the cycle before reset asserts SHALL have its result overridden to 0.

Configuration
REQ-036 With macro PLB_RESPONDER_OUTREG_EN defined, PLB_dout and host_dout SHALL each gain one output register stage, giving read latency 2.
REQ-037 With PLB_RESPONDER_OUTREG_EN defined, the extra output register stages SHALL reset to 0.
REQ-038 With PLB_RESPONDER_OUTREG_EN undefined, read latency SHALL be 1.
REQ-039 All other behaviour SHALL be identical with and without PLB_RESPONDER_OUTREG_EN.

Verification
REQ-040 Host writes 0x12345678 to address 5, then PL reads PLB_addr=5 -> PLB_dout=0x12345678 one cycle later (two cycles with PLB_RESPONDER_OUTREG_EN); plb_rd_cnt=1.
REQ-041 Host holds address 3=0xAAAA0000; PL writes 0x5A to address 3 while host reads address 3 in the same cycle -> host_dout=0xAAAA0000; a following host read returns 0x5A.
REQ-042 Both ports write address 7 in the same cycle (PL 0x1, host 0x2) -> a later read of address 7 returns 0x1; err_coll=1.
REQ-043 PL writes to PLB_addr=0x400 (AW=10) -> array unchanged; err_oor=1; plb_wr_cnt=0; a PL read of 0x400 returns 0.
REQ-044 With CW=4, issue 20 in-range PL writes -> plb_wr_cnt=15.
REQ-045 Pulse sys_rst for 1 cycle -> counters and flags are 0, and address 5 still reads 0x12345678.

Source files
------------

// File: rtl/plb_responder.sv
// Dual-port word memory with a bounds-checked PL-side port, a host-side port, access counters and sticky error flags.
// Optional macro PLB_RESPONDER_OUTREG_EN adds one output register stage per port (read latency 2 instead of 1).
module plb_responder #(
  parameter int DW = 32,
  parameter int AW = 10,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 PLB_en,
  input  logic                 PLB_we,
  input  logic [31:0]          PLB_addr,
  input  logic signed [DW-1:0] PLB_din,
  output logic signed [DW-1:0] PLB_dout,
  input  logic                 host_en,
  input  logic                 host_we,
  input  logic [AW-1:0]        host_addr,
  input  logic [DW-1:0]        host_din,
  output logic [DW-1:0]        host_dout,
  output logic [CW-1:0]        plb_wr_cnt,
  output logic [CW-1:0]        plb_rd_cnt,
  output logic                 err_oor,
  output logic                 err_coll
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pl_rdata;
  logic [DW-1:0] host_rdata;
  logic          pl_in_range;
  logic [AW-1:0] pl_idx;
  logic          pl_wr;
  logic          pl_rd;
  logic          pl_oor;
  logic          host_wr_req;
  logic          host_rd;
  logic          coll;
  logic          host_wr;

  // Requests arriving during reset are discarded, so every enable is qualified here.
  assign pl_in_range = (PLB_addr[31:AW] == '0);
  assign pl_idx      = PLB_addr[AW-1:0];
  assign pl_wr       = PLB_en & PLB_we & pl_in_range & ~sys_rst;
  assign pl_rd       = PLB_en & ~PLB_we & ~sys_rst;
  assign pl_oor      = PLB_en & ~pl_in_range & ~sys_rst;
  assign host_wr_req = host_en & host_we & ~sys_rst;
  assign host_rd     = host_en & ~host_we & ~sys_rst;
  assign coll        = pl_wr & host_wr_req & (host_addr == pl_idx);
  assign host_wr     = host_wr_req & ~coll;

  always_ff @(posedge clk) begin
    if (host_wr) mem[host_addr] <= host_din;
    if (pl_wr)   mem[pl_idx]    <= PLB_din;
  end

  // Reads sample the array before this edge's writes land, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pl_rdata   <= '0;
      host_rdata <= '0;
    end else begin
      if (pl_rd)   pl_rdata   <= pl_in_range ? mem[pl_idx] : '0;
      if (host_rd) host_rdata <= mem[host_addr];
    end
  end

`ifdef PLB_RESPONDER_OUTREG_EN
  logic [DW-1:0] pl_rdata_q;
  logic [DW-1:0] host_rdata_q;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pl_rdata_q   <= '0;
      host_rdata_q <= '0;
    end else begin
      pl_rdata_q   <= pl_rdata;
      host_rdata_q <= host_rdata;
    end
  end

  assign PLB_dout  = pl_rdata_q;
  assign host_dout = host_rdata_q;
`else
  assign PLB_dout  = pl_rdata;
  assign host_dout = host_rdata;
`endif

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      plb_wr_cnt <= '0;
      plb_rd_cnt <= '0;
      err_oor    <= 1'b0;
      err_coll   <= 1'b0;
    end else begin
      if (pl_wr && plb_wr_cnt != '1)                plb_wr_cnt <= plb_wr_cnt + CW'(1);
      if (pl_rd && pl_in_range && plb_rd_cnt != '1) plb_rd_cnt <= plb_rd_cnt + CW'(1);
      if (pl_oor) err_oor  <= 1'b1;
      if (coll)   err_coll <= 1'b1;
    end
  end

endmodule

// File: tb/tb_plb_responder.sv
// Directed self-checking bench for plb_responder (CW=4 so counter saturation is reachable quickly).
module tb_plb_responder;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 4;
`ifdef PLB_RESPONDER_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 sys_rst;
  logic                 PLB_en;
  logic                 PLB_we;
  logic [31:0]          PLB_addr;
  logic signed [DW-1:0] PLB_din;
  logic signed [DW-1:0] PLB_dout;
  logic                 host_en;
  logic                 host_we;
  logic [AW-1:0]        host_addr;
  logic [DW-1:0]        host_din;
  logic [DW-1:0]        host_dout;
  logic [CW-1:0]        plb_wr_cnt;
  logic [CW-1:0]        plb_rd_cnt;
  logic                 err_oor;
  logic                 err_coll;

  int checks = 0;
  int failures = 0;

  plb_responder #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .PLB_en(PLB_en), .PLB_we(PLB_we), .PLB_addr(PLB_addr), .PLB_din(PLB_din), .PLB_dout(PLB_dout),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_din(host_din), .host_dout(host_dout),
    .plb_wr_cnt(plb_wr_cnt), .plb_rd_cnt(plb_rd_cnt), .err_oor(err_oor), .err_coll(err_coll)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PLB_en  = 1'b0;
    PLB_we  = 1'b0;
    host_en = 1'b0;
    host_we = 1'b0;
  endtask

  // Drives one cycle of requests on both ports, then returns both ports to idle.
  task automatic applyStimulus(input logic pe, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                               input logic he, input logic hw, input logic [AW-1:0] ha, input logic [31:0] hd);
    PLB_en    = pe;
    PLB_we    = pw;
    PLB_addr  = pa;
    PLB_din   = pd;
    host_en   = he;
    host_we   = hw;
    host_addr = ha;
    host_din  = hd;
    tick();
    idle();
  endtask

  task automatic settle();
    repeat (LAT - 1) tick();
  endtask

  initial begin
    sys_rst   = 1'b1;
    PLB_addr  = '0;
    PLB_din   = '0;
    host_addr = '0;
    host_din  = '0;
    idle();
    tick();
    tick();
    sys_rst = 1'b0;
    checkOutput("rst_pl_dout",   PLB_dout,   32'h0);
    checkOutput("rst_host_dout", host_dout,  32'h0);
    checkOutput("rst_wr_cnt",    plb_wr_cnt, 32'h0);
    checkOutput("rst_rd_cnt",    plb_rd_cnt, 32'h0);
    checkOutput("rst_err_oor",   err_oor,    32'h0);
    checkOutput("rst_err_coll",  err_coll,   32'h0);

    // Host write then PL read of the same word
    applyStimulus(0, 0, 0, 0, 1, 1, 5, 32'h12345678);
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0);
    settle();
    checkOutput("pl_read_a5", PLB_dout, 32'h12345678);
    checkOutput("rd_cnt_1",   plb_rd_cnt, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 5, 0);
    settle();
    checkOutput("host_read_a5", host_dout, 32'h12345678);

    // Cross-port read-during-write returns the old word
    applyStimulus(0, 0, 0, 0, 1, 1, 3, 32'hAAAA0000);
    applyStimulus(1, 1, 3, 32'h5A, 1, 0, 3, 0);
    settle();
    checkOutput("host_rdw_old",     host_dout,  32'hAAAA0000);
    checkOutput("pl_dout_on_write", PLB_dout,   32'h12345678);
    checkOutput("wr_cnt_1",         plb_wr_cnt, 32'd1);
    checkOutput("no_coll_yet",      err_coll,   32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 3, 0);
    settle();
    checkOutput("host_read_new", host_dout, 32'h5A);

    // Same-address write collision: PL wins
    applyStimulus(1, 1, 7, 32'h1, 1, 1, 7, 32'h2);
    checkOutput("err_coll_set", err_coll,   32'h1);
    checkOutput("wr_cnt_2",     plb_wr_cnt, 32'd2);
    checkOutput("no_oor_yet",   err_oor,    32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 7, 0);
    settle();
    checkOutput("coll_pl_wins", host_dout, 32'h1);

    // Out-of-range PL write must not alias onto word 0
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'h0BADF00D);
    applyStimulus(1, 1, 32'h400, 32'hDEAD, 0, 0, 0, 0);
    checkOutput("err_oor_set",   err_oor,    32'h1);
    checkOutput("oor_wr_no_cnt", plb_wr_cnt, 32'd2);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    settle();
    checkOutput("oor_no_alias", host_dout, 32'h0BADF00D);
    applyStimulus(1, 0, 32'h400, 0, 0, 0, 0, 0);
    settle();
    checkOutput("oor_read_zero", PLB_dout,   32'h0);
    checkOutput("oor_rd_no_cnt", plb_rd_cnt, 32'd1);

    // dout holds while idle
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0);
    settle();
    checkOutput("rd_cnt_2", plb_rd_cnt, 32'd2);
    repeat (3) tick();
    checkOutput("pl_dout_hold", PLB_dout, 32'h12345678);

    // Write counter saturation: 2 + 20 writes clamps at 15
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 1, 32'(100 + i), 32'(i * 3 + 1), 0, 0, 0, 0);
    checkOutput("wr_cnt_sat",    plb_wr_cnt, 32'd15);
    checkOutput("err_coll_stky", err_coll,   32'h1);
    checkOutput("err_oor_stky",  err_oor,    32'h1);
    applyStimulus(1, 0, 119, 0, 0, 0, 0, 0);
    settle();
    checkOutput("pl_read_a119", PLB_dout,   32'd58);
    checkOutput("rd_cnt_3",     plb_rd_cnt, 32'd3);

    // Read just before reset, writes during reset are discarded
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0);
    sys_rst = 1'b1;
    applyStimulus(1, 1, 5, 32'hFFFF, 1, 1, 5, 32'hEEEE);
    sys_rst = 1'b0;
    checkOutput("rst2_pl_dout",  PLB_dout,   32'h0);
    checkOutput("rst2_wr_cnt",   plb_wr_cnt, 32'h0);
    checkOutput("rst2_rd_cnt",   plb_rd_cnt, 32'h0);
    checkOutput("rst2_err_oor",  err_oor,    32'h0);
    checkOutput("rst2_err_coll", err_coll,   32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 5, 0);
    settle();
    checkOutput("mem_kept_a5", host_dout, 32'h12345678);
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0);
    settle();
    checkOutput("post_rst_pl_a5", PLB_dout,   32'h12345678);
    checkOutput("post_rst_rd",    plb_rd_cnt, 32'd1);
    checkOutput("post_rst_wr",    plb_wr_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
